// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped I/O bank: register offsets,
// STAT bit positions and the decoder enable code for this bank.
package mmio_pkg;

    typedef enum logic [1:0] {
        REG_STAT   = 2'd0,
        REG_KBDATA = 2'd1,
        REG_TCOUNT = 2'd2,
        REG_TCMP   = 2'd3
    } reg_off_e;

    localparam logic [2:0] MMIO_BANK_EN = 3'b100;

    localparam int STAT_KB_NOT_EMPTY = 0;
    localparam int STAT_KB_FULL      = 1;
    localparam int STAT_KB_OVF       = 2;
    localparam int STAT_T_PEND       = 3;
    localparam int STAT_COUNT_LSB    = 4;
    localparam int STAT_T_EN         = 8;
    localparam int STAT_T_IRQ_EN     = 9;
    localparam int STAT_KB_IRQ_EN    = 10;

endpackage

// File: rtl/kb_fifo.sv
// Synchronous byte FIFO for keyboard scan codes. A pop on an empty FIFO is
// ignored; a push on a full FIFO only succeeds if a pop frees a slot in the
// same cycle, in which case the new byte lands in the slot just vacated.
module kb_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rstN,
    input  logic                   push,
    input  logic [7:0]             din,
    input  logic                   pop,
    output logic [7:0]             dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_count;
    logic          w_doPop;
    logic          w_doPush;

    assign empty    = (r_count == '0);
    assign full     = (r_count == (AW+1)'(DEPTH));
    assign w_doPop  = pop & ~empty;
    assign w_doPush = push & (~full | w_doPop);
    assign dout     = empty ? 8'h00 : r_mem[r_rdPtr];
    assign count    = r_count;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
            if (w_doPush && !w_doPop)      r_count <= r_count + 1'b1;
            else if (w_doPop && !w_doPush) r_count <= r_count - 1'b1;
        end
    end

    // Byte storage; contents are meaningless while empty so no reset needed.
    always_ff @(posedge clk) begin
        if (w_doPush) r_mem[r_wrPtr] <= din;
    end

endmodule

// File: rtl/mmio_io_bank.sv
// Memory-mapped I/O bank: STAT/control, keyboard FIFO data port, prescaled
// timer with compare event, and a level interrupt to the CPU.
module mmio_io_bank
    import mmio_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int PRESCALE   = 50000
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic [12:0] pAd,
    input  logic [2:0]  mE,
    input  logic        mW,
    input  logic        mR,
    input  logic [31:0] wData,
    output logic [31:0] rData,
    input  logic        kbValid,
    input  logic [7:0]  kbData,
    output logic        kbFull,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    reg_off_e      w_off;
    logic          w_sel;
    logic          w_wr;
    logic          w_statWr;
    logic          w_rdKb;
    logic          w_tick;
    logic          w_match;
    logic          w_pendSet;
    logic          w_ovfSet;
    logic [7:0]    w_kbHead;
    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    logic [31:0]   w_stat;
    logic          w_unusedAd;

    logic [PW-1:0] r_pre;
    logic [31:0]   r_tcount;
    logic [31:0]   r_tcmp;
    logic          r_tPend;
    logic          r_kbOvf;
    logic          r_tEn;
    logic          r_tIrqEn;
    logic          r_kbIrqEn;

    assign w_off      = reg_off_e'(pAd[3:2]);
    assign w_unusedAd = ^{pAd[12:4], pAd[1:0]};
    assign w_sel      = (mE == MMIO_BANK_EN) & (mW | mR);
    assign w_wr       = w_sel & mW;
    assign w_statWr   = w_wr & (w_off == REG_STAT);
    assign w_rdKb     = w_sel & mR & (w_off == REG_KBDATA);
    assign w_tick     = r_tEn & (r_pre == PRE_LAST);
    assign w_match    = (r_tcount == r_tcmp);
    assign w_pendSet  = w_tick & w_match;
    assign w_ovfSet   = kbValid & w_full & ~w_rdKb;
    assign kbFull     = w_full;
    assign irq        = (r_tPend & r_tIrqEn) | (~w_empty & r_kbIrqEn);

    kb_fifo #(.DEPTH(FIFO_DEPTH)) u_kbFifo (
        .clk   (clk),
        .rstN  (rstN),
        .push  (kbValid),
        .din   (kbData),
        .pop   (w_rdKb),
        .dout  (w_kbHead),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    // Prescaler free-runs while the timer is enabled and is held at zero otherwise.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_pre <= '0;
        end else if (!r_tEn || w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // Timer count and compare; a CPU write to TCOUNT beats a simultaneous tick.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_tcount <= '0;
            r_tcmp   <= '0;
        end else begin
            if (w_wr && (w_off == REG_TCOUNT)) r_tcount <= wData;
            else if (w_tick)                   r_tcount <= w_match ? 32'h0 : r_tcount + 32'h1;
            if (w_wr && (w_off == REG_TCMP))   r_tcmp   <= wData;
        end
    end

    // Sticky flags (set beats write-1-to-clear) and control enables from STAT.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_tPend   <= 1'b0;
            r_kbOvf   <= 1'b0;
            r_tEn     <= 1'b0;
            r_tIrqEn  <= 1'b0;
            r_kbIrqEn <= 1'b0;
        end else begin
            r_tPend <= w_pendSet | (r_tPend & ~(w_statWr & wData[STAT_T_PEND]));
            r_kbOvf <= w_ovfSet  | (r_kbOvf & ~(w_statWr & wData[STAT_KB_OVF]));
            if (w_statWr) begin
                r_tEn     <= wData[STAT_T_EN];
                r_tIrqEn  <= wData[STAT_T_IRQ_EN];
                r_kbIrqEn <= wData[STAT_KB_IRQ_EN];
            end
        end
    end

    // Assemble the STAT read image from live FIFO state and the flag registers.
    always_comb begin
        w_stat = (32'(w_count) << STAT_COUNT_LSB) & (32'hF << STAT_COUNT_LSB);
        w_stat[STAT_KB_NOT_EMPTY] = ~w_empty;
        w_stat[STAT_KB_FULL]      = w_full;
        w_stat[STAT_KB_OVF]       = r_kbOvf;
        w_stat[STAT_T_PEND]       = r_tPend;
        w_stat[STAT_T_EN]         = r_tEn;
        w_stat[STAT_T_IRQ_EN]     = r_tIrqEn;
        w_stat[STAT_KB_IRQ_EN]    = r_kbIrqEn;
    end

    // Read mux; the bus reads zero whenever this bank is not selected.
    always_comb begin
        rData = 32'h0;
        if (w_sel) begin
            case (w_off)
                REG_STAT:   rData = w_stat;
                REG_KBDATA: rData = {24'h0, w_kbHead};
                REG_TCOUNT: rData = r_tcount;
                REG_TCMP:   rData = r_tcmp;
                default:    rData = 32'h0;
            endcase
        end
    end

endmodule
